// File: rtl/t_ff_bank_if.sv
// Control/status bundle for the T flip-flop bank.
interface t_ff_bank_if #(
  parameter int unsigned WIDTH = 8
);

  logic             en;       // global toggle enable
  logic [1:0]       mode;     // 00 INDEP, 01 UP, 10 DOWN, 11 INVERT
  logic [WIDTH-1:0] t;        // per-bit toggle request, or t[0] as step request
  logic             load;     // synchronous parallel load
  logic [WIDTH-1:0] d;        // load data
  logic [WIDTH-1:0] q;        // flip-flop state
  logic [WIDTH-1:0] qb;       // inverted state
  logic [WIDTH-1:0] toggled;  // bits that changed at the last edge
  logic             tc;       // terminal count

  // Stimulus side
  modport master (
    output en, mode, t, load, d,
    input  q, qb, toggled, tc
  );

  // Bank side
  modport slave (
    input  en, mode, t, load, d,
    output q, qb, toggled, tc
  );

endinterface

// File: rtl/t_ff_bank.sv
// Bank of WIDTH toggle flip-flops with per-bit enables, parallel load and
// chained up/down counting or whole-word inversion.
module t_ff_bank #(
  parameter int unsigned         WIDTH     = 8,
  parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rest,
  t_ff_bank_if.slave      bus
);

  typedef enum logic [1:0] {
    ModeIndep  = 2'b00,
    ModeUp     = 2'b01,
    ModeDown   = 2'b10,
    ModeInvert = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] toggled_q, toggled_d;
  logic [WIDTH-1:0] up_mask;
  logic [WIDTH-1:0] down_mask;
  logic [WIDTH-1:0] tmask;
  logic             all_ones;
  logic             all_zeros;

  assign mode      = mode_e'(bus.mode);
  assign all_ones  = &q_q;
  assign all_zeros = ~|q_q;

  // Ripple-free carry/borrow masks: bit i toggles when every lower bit is 1 (up) or 0 (down)
  always_comb begin : mask_chain
    logic carry;
    logic borrow;
    carry     = 1'b1;
    borrow    = 1'b1;
    up_mask   = '0;
    down_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      up_mask[i]   = bus.t[0] & carry;
      down_mask[i] = bus.t[0] & borrow;
      carry        = carry & q_q[i];
      borrow       = borrow & ~q_q[i];
    end
  end

  // Toggle mask selection; only t[0] feeds the chained modes so t[WIDTH-1:1] cannot leak X
  always_comb begin
    tmask = '0;
    unique case (mode)
      ModeIndep:  tmask = bus.t;
      ModeUp:     tmask = up_mask;
      ModeDown:   tmask = down_mask;
      ModeInvert: tmask = {WIDTH{bus.t[0]}};
      default:    tmask = '0;
    endcase
  end

  // Next-state: load beats enable; reset is applied in the register process
  always_comb begin
    q_d       = q_q;
    toggled_d = '0;
    if (bus.load) begin
      q_d       = bus.d;
      toggled_d = q_q ^ bus.d;
    end else if (bus.en) begin
      q_d       = q_q ^ tmask;
      toggled_d = tmask;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rest) begin
      q_q       <= RESET_VAL;
      toggled_q <= '0;
    end else begin
      q_q       <= q_d;
      toggled_q <= toggled_d;
    end
  end

  // Outputs; tc flags the step that wraps the counter
  assign bus.q       = q_q;
  assign bus.qb      = ~q_q;
  assign bus.toggled = toggled_q;
  assign bus.tc      = bus.en & ~bus.load & ~rest & bus.t[0] &
                       (((mode == ModeUp) & all_ones) | ((mode == ModeDown) & all_zeros));

endmodule

// File: tb/tb_t_ff_bank.sv
module tb_t_ff_bank;

  logic clk = 1'b0;
  logic rest_a;
  logic rest_b;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] exp_q;
  logic [3:0] prev_q;

  always #5 clk = ~clk;

  t_ff_bank_if #(.WIDTH(4)) bus_a ();
  t_ff_bank_if #(.WIDTH(4)) bus_b ();

  t_ff_bank #(.WIDTH(4), .RESET_VAL(4'h0)) dut_a (
    .clk  (clk),
    .rest (rest_a),
    .bus  (bus_a)
  );

  t_ff_bank #(.WIDTH(4), .RESET_VAL(4'hC)) dut_b (
    .clk  (clk),
    .rest (rest_b),
    .bus  (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_tests++;
    assert (obs === req)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset for two edges with random controls
    rest_a = 1'b1;
    rest_b = 1'b1;
    bus_a.mode = 2'($urandom_range(3));
    bus_b.mode = 2'b00;
    bus_b.en = 1'b0;
    bus_b.load = 1'b0;
    bus_b.t = 4'h0;
    bus_b.d = 4'h0;
    for (int i = 0; i < 2; i++) begin
      bus_a.en   = 1'($urandom_range(1));
      bus_a.load = 1'($urandom_range(1));
      bus_a.t    = 4'($urandom_range(15));
      bus_a.d    = 4'($urandom_range(15));
      tick();
      chk("rst_q", bus_a.q, 4'h0);
      chk("rst_qb", bus_a.qb, 4'hF);
      chk("rst_tog", bus_a.toggled, 4'h0);
      chk("rst_tc", bus_a.tc, 1'b0);
    end
    chk("rst_q_b", bus_b.q, 4'hC);
    chk("rst_qb_b", bus_b.qb, 4'h3);

    // 2: independent toggles
    rest_a = 1'b0;
    bus_a.load = 1'b0;
    bus_a.en = 1'b1;
    bus_a.mode = 2'b00;
    bus_a.t = 4'b0101;
    #1;
    chk("indep_tc", bus_a.tc, 1'b0);
    tick();
    chk("indep_q1", bus_a.q, 4'b0101);
    chk("indep_tog1", bus_a.toggled, 4'b0101);
    tick();
    chk("indep_q2", bus_a.q, 4'b0000);
    chk("indep_tog2", bus_a.toggled, 4'b0101);

    // 3: up count over a full wrap; upper t bits must be ignored
    bus_a.mode = 2'b01;
    bus_a.t = 4'b1010 | 4'b0001;
    exp_q = 4'h0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("up_tc", bus_a.tc, (exp_q == 4'hF) ? 1'b1 : 1'b0);
      prev_q = exp_q;
      exp_q  = exp_q + 4'd1;
      tick();
      chk("up_q", bus_a.q, exp_q);
      chk("up_tog", bus_a.toggled, prev_q ^ exp_q);
    end
    chk("up_wrap_tog", bus_a.toggled, 4'hF);
    chk("up_wrap_qb", bus_a.qb, 4'hF);

    // 4: down count from zero, then a hold
    bus_a.mode = 2'b10;
    bus_a.t = 4'b0001;
    #1;
    chk("dn_tc0", bus_a.tc, 1'b1);
    tick();
    chk("dn_q_f", bus_a.q, 4'hF);
    chk("dn_tog_f", bus_a.toggled, 4'hF);
    chk("dn_tc_f", bus_a.tc, 1'b0);
    tick();
    chk("dn_q_e", bus_a.q, 4'hE);
    tick();
    chk("dn_q_d", bus_a.q, 4'hD);
    chk("dn_tog_d", bus_a.toggled, 4'h3);
    bus_a.en = 1'b0;
    #1;
    chk("hold_tc", bus_a.tc, 1'b0);
    tick();
    chk("hold_q", bus_a.q, 4'hD);
    chk("hold_tog", bus_a.toggled, 4'h0);
    bus_a.en = 1'b1;
    tick();
    chk("dn_q_c", bus_a.q, 4'hC);
    chk("dn_tog_c", bus_a.toggled, 4'h1);

    // 5: load overrides counting, reset overrides load, then inversion
    bus_a.mode = 2'b01;
    bus_a.load = 1'b1;
    bus_a.d = 4'b1010;
    #1;
    chk("load_tc", bus_a.tc, 1'b0);
    tick();
    chk("load_q", bus_a.q, 4'hA);
    chk("load_tog", bus_a.toggled, 4'h6);
    bus_a.d = 4'b0110;
    rest_a = 1'b1;
    tick();
    chk("rst_over_load_q", bus_a.q, 4'h0);
    chk("rst_over_load_tog", bus_a.toggled, 4'h0);
    rest_a = 1'b0;
    bus_a.d = 4'b1010;
    tick();
    chk("reload_q", bus_a.q, 4'hA);
    chk("reload_tog", bus_a.toggled, 4'hA);
    bus_a.load = 1'b0;
    bus_a.d = 4'bxxxx;
    bus_a.mode = 2'b11;
    bus_a.t = 4'bxxx1;
    #1;
    chk("inv_tc", bus_a.tc, 1'b0);
    tick();
    chk("inv_q1", bus_a.q, 4'b0101);
    chk("inv_tog1", bus_a.toggled, 4'hF);
    tick();
    chk("inv_q2", bus_a.q, 4'b1010);
    chk("inv_qb2", bus_a.qb, 4'b0101);

    // 6: non-zero reset value interrupting an up count
    rest_b = 1'b0;
    bus_b.load = 1'b1;
    bus_b.d = 4'h6;
    tick();
    chk("b_load_q", bus_b.q, 4'h6);
    bus_b.load = 1'b0;
    bus_b.en = 1'b1;
    bus_b.mode = 2'b01;
    bus_b.t = 4'b0001;
    tick();
    chk("b_up_q7", bus_b.q, 4'h7);
    chk("b_up_tog7", bus_b.toggled, 4'h1);
    rest_b = 1'b1;
    #1;
    chk("b_rst_tc", bus_b.tc, 1'b0);
    tick();
    chk("b_rst_q", bus_b.q, 4'hC);
    chk("b_rst_tog", bus_b.toggled, 4'h0);
    rest_b = 1'b0;
    tick();
    chk("b_resume_q", bus_b.q, 4'hD);
    chk("b_resume_qb", bus_b.qb, 4'h2);
    chk("b_resume_tog", bus_b.toggled, 4'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
